// File: rtl/score_collector_if.sv
// Output stream of the score collector: valid/ready handshake carrying an ID and an
// unbiased signed score.
interface score_collector_if #(
  parameter int unsigned SCORE_WIDTH = 12,
  parameter int unsigned ID_WIDTH    = 48
);
  logic                          out_valid;
  logic                          out_ready;
  logic [ID_WIDTH-1:0]           out_id;
  logic signed [SCORE_WIDTH-1:0] out_score;

  modport master (
    output out_valid,
    output out_id,
    output out_score,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_id,
    input  out_score,
    output out_ready
  );
endinterface

// File: rtl/score_collector.sv
// Collects per-channel scoring results on the rising edge of vld, arbitrates them
// round-robin into a thresholded output FIFO and tracks the per-query maximum.
module score_collector #(
  parameter int unsigned SCORE_WIDTH = 12,
  parameter int unsigned ID_WIDTH    = 48,
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned ZERO        = 2 ** (SCORE_WIDTH - 1)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [CHANNELS*SCORE_WIDTH-1:0]   results,
  input  logic [CHANNELS*ID_WIDTH-1:0]      IDs,
  input  logic [CHANNELS-1:0]               vld,
  input  logic signed [SCORE_WIDTH-1:0]     threshold,
  input  logic                              clear_max,
  score_collector_if.master                 out,
  output logic [ID_WIDTH+SCORE_WIDTH-1:0]   max,
  output logic                              vld_max,
  output logic                              dropped
);

  localparam int unsigned PtrW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = AddrW + 1;
  localparam logic [SCORE_WIDTH-1:0] Bias = SCORE_WIDTH'(ZERO);

  typedef struct packed {
    logic [ID_WIDTH-1:0]    id;
    logic [SCORE_WIDTH-1:0] score;
  } entry_t;

  // Channel view: channel 0 occupies the MSBs of every bus.
  logic [SCORE_WIDTH-1:0]        ch_score [CHANNELS];
  logic [ID_WIDTH-1:0]           ch_id    [CHANNELS];
  logic [CHANNELS-1:0]           ch_vld;

  logic [CHANNELS-1:0]           vld_prev_q;
  logic [CHANNELS-1:0]           pend_q, pend_d;
  logic [SCORE_WIDTH-1:0]        hold_score_q [CHANNELS];
  logic [ID_WIDTH-1:0]           hold_id_q    [CHANNELS];
  logic signed [SCORE_WIDTH-1:0] hold_unb     [CHANNELS];

  logic [CHANNELS-1:0]           cap, below, elig, gnt_oh;
  logic                          gnt_vld, push, drop_evt, full;
  logic [PtrW-1:0]               gnt_idx, ptr_q, ptr_d;
  int unsigned                   idx;

  logic [ID_WIDTH+SCORE_WIDTH-1:0] max_q;
  logic                            vld_max_q, dropped_q;

  entry_t                        mem [FIFO_DEPTH];
  logic [AddrW-1:0]              wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]               cnt_q, cnt_d;
  logic                          pop, load;
  logic                          out_valid_q;
  logic [ID_WIDTH-1:0]           out_id_q;
  logic [SCORE_WIDTH-1:0]        out_score_q;

  always_comb begin
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      ch_score[c] = results[(CHANNELS-1-c)*SCORE_WIDTH +: SCORE_WIDTH];
      ch_id[c]    = IDs[(CHANNELS-1-c)*ID_WIDTH +: ID_WIDTH];
      ch_vld[c]   = vld[CHANNELS-1-c];
      hold_unb[c] = hold_score_q[c] - Bias;
      below[c]    = hold_unb[c] < threshold;
    end
  end

  assign full = (cnt_q + CntW'(out_valid_q)) == CntW'(FIFO_DEPTH);
  assign cap  = ch_vld & ~vld_prev_q;
  // A full FIFO only blocks entries that would actually be written.
  assign elig = pend_q & ({CHANNELS{~full}} | below);

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (!gnt_vld && elig[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = PtrW'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_vld) ptr_d = (gnt_idx == PtrW'(CHANNELS - 1)) ? '0 : gnt_idx + PtrW'(1);
    push = gnt_vld && !below[gnt_idx];
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      gnt_oh[c] = gnt_vld && (gnt_idx == PtrW'(c));
      pend_d[c] = cap[c] ? 1'b1 : (gnt_oh[c] ? 1'b0 : pend_q[c]);
    end
    drop_evt = |(cap & pend_q & ~gnt_oh);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_prev_q <= '0;
      pend_q     <= '0;
      ptr_q      <= '0;
      dropped_q  <= 1'b0;
    end else begin
      vld_prev_q <= ch_vld;
      pend_q     <= pend_d;
      ptr_q      <= ptr_d;
      if (drop_evt) dropped_q <= 1'b1;
    end
  end

  // Holding registers keep the old value when a capture is discarded.
  always_ff @(posedge clk) begin
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (cap[c] && (!pend_q[c] || gnt_oh[c])) begin
        hold_score_q[c] <= ch_score[c];
        hold_id_q[c]    <= ch_id[c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      max_q     <= '0;
      vld_max_q <= 1'b0;
    end else if (gnt_vld && (clear_max || !vld_max_q ||
                             hold_score_q[gnt_idx] > max_q[SCORE_WIDTH-1:0])) begin
      max_q     <= {hold_id_q[gnt_idx], hold_score_q[gnt_idx]};
      vld_max_q <= 1'b1;
    end else if (clear_max) begin
      max_q     <= '0;
      vld_max_q <= 1'b0;
    end
  end

  // FIFO storage plus a registered head; the head counts towards capacity.
  assign pop   = out_valid_q && out.out_ready;
  assign load  = (cnt_q != '0) && (!out_valid_q || pop);
  assign cnt_d = cnt_q + CntW'(push) - CntW'(load);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= '{id: hold_id_q[gnt_idx], score: hold_unb[gnt_idx]};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_score_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + AddrW'(1);
      if (load) begin
        rd_ptr_q    <= rd_ptr_q + AddrW'(1);
        out_valid_q <= 1'b1;
        out_id_q    <= mem[rd_ptr_q].id;
        out_score_q <= mem[rd_ptr_q].score;
      end else if (pop) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out.out_valid = out_valid_q;
  assign out.out_id    = out_id_q;
  assign out.out_score = out_score_q;
  assign max           = max_q;
  assign vld_max       = vld_max_q;
  assign dropped       = dropped_q;

endmodule

// File: tb/tb_score_collector.sv
// Directed scenarios plus a randomized phase checked against a transaction-level
// model of which results must appear on the stream and what the query maximum is.
module tb_score_collector;
  localparam int SW   = 12;
  localparam int IW   = 48;
  localparam int C    = 4;
  localparam int D    = 16;
  localparam int ZERO = 2048;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic [C*SW-1:0]      results;
  logic [C*IW-1:0]      IDs;
  logic [C-1:0]         vld;
  logic signed [SW-1:0] threshold;
  logic                 clear_max;
  logic [IW+SW-1:0]     max;
  logic                 vld_max;
  logic                 dropped;

  score_collector_if #(.SCORE_WIDTH(SW), .ID_WIDTH(IW)) sif ();

  score_collector #(
    .SCORE_WIDTH(SW), .ID_WIDTH(IW), .CHANNELS(C), .FIFO_DEPTH(D), .ZERO(ZERO)
  ) dut (
    .clk(clk), .rst(rst), .results(results), .IDs(IDs), .vld(vld),
    .threshold(threshold), .clear_max(clear_max), .out(sif),
    .max(max), .vld_max(vld_max), .dropped(dropped)
  );

  typedef struct {
    logic [IW-1:0] id;
    int            unb;
    int            biased;
  } rec_t;

  int                   total = 0;
  int                   bad = 0;
  logic [IW-1:0]        got_id[$];
  logic signed [SW-1:0] got_sc[$];
  rec_t                 exp_q[$];
  rec_t                 all_q[$];
  rec_t                 r;
  int                   cool[C];
  int                   thr, best, fidx, cnt, nid, bval;
  bit                   prev_hold, found;
  logic [IW-1:0]        prev_id, head, nid_v;
  logic signed [SW-1:0] prev_sc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_s(input string tag, input logic signed [SW-1:0] obs, input int expv);
    logic [SW-1:0] e;
    e = expv[SW-1:0];
    total++;
    assert (obs === e) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic set_ch(input int c, input logic [IW-1:0] id, input int biased);
    results[(C-1-c)*SW +: SW] = biased[SW-1:0];
    IDs[(C-1-c)*IW +: IW]     = id;
  endtask

  function automatic logic [C-1:0] vbit(input int c);
    logic [C-1:0] v;
    v = '0;
    v[C-1-c] = 1'b1;
    return v;
  endfunction

  // One clock; records a handshake that completes at this edge.
  task automatic cyc();
    if (sif.out_valid && sif.out_ready) begin
      got_id.push_back(sif.out_id);
      got_sc.push_back(sif.out_score);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clr_got();
    got_id.delete();
    got_sc.delete();
  endtask

  initial begin
    rst = 1'b0; vld = '0; results = '0; IDs = '0; threshold = '0; clear_max = 1'b0;
    sif.out_ready = 1'b1;
    cyc(); cyc();
    chk("rst_valid", 64'(sif.out_valid), 64'd0);
    chk("rst_id", 64'(sif.out_id), 64'd0);
    chk_s("rst_score", sif.out_score, 0);
    chk("rst_max", 64'(max), 64'd0);
    chk("rst_vld_max", 64'(vld_max), 64'd0);
    chk("rst_dropped", 64'(dropped), 64'd0);
    rst = 1'b1;
    cyc();

    // Single result, valid held high for many cycles
    clr_got();
    set_ch(0, 48'd7, 2058);
    vld = vbit(0);
    cyc();
    chk("s1_valid_n0", 64'(sif.out_valid), 64'd0);
    cyc();
    chk("s1_max", 64'(max), 64'({48'd7, 12'd2058}));
    chk("s1_vld_max", 64'(vld_max), 64'd1);
    chk("s1_valid_n1", 64'(sif.out_valid), 64'd0);
    cyc();
    chk("s1_valid_n2", 64'(sif.out_valid), 64'd1);
    chk("s1_id", 64'(sif.out_id), 64'd7);
    chk_s("s1_score", sif.out_score, 10);
    repeat (20) cyc();
    vld = '0;
    cyc();
    chk("s1_count", 64'(got_id.size()), 64'd1);

    // Fairness: all channels rise together after reset
    rst = 1'b0; cyc(); rst = 1'b1;
    clr_got();
    for (int c = 0; c < C; c++) set_ch(c, IW'(c + 1), 2050 + c);
    vld = '1;
    cyc(); cyc(); cyc();
    for (int k = 0; k < C; k++) begin
      chk("s2_valid", 64'(sif.out_valid), 64'd1);
      chk("s2_id", 64'(sif.out_id), 64'(k + 1));
      chk_s("s2_score", sif.out_score, 2 + k);
      cyc();
    end
    vld = '0;
    chk("s2_drained", 64'(sif.out_valid), 64'd0);
    chk("s2_max", 64'(max), 64'({48'd4, 12'd2053}));

    // Threshold and ties
    clear_max = 1'b1; cyc(); clear_max = 1'b0;
    threshold = 12'sd5;
    clr_got();
    set_ch(0, 48'd10, 2051); vld = vbit(0); cyc(); vld = '0; cyc(); cyc();
    set_ch(1, 48'd11, 2056); vld = vbit(1); cyc(); vld = '0; cyc(); cyc();
    set_ch(2, 48'd12, 2056); vld = vbit(2); cyc(); vld = '0;
    repeat (6) cyc();
    chk("s3_count", 64'(got_id.size()), 64'd2);
    if (got_id.size() == 2) begin
      chk("s3_id0", 64'(got_id[0]), 64'd11);
      chk("s3_id1", 64'(got_id[1]), 64'd12);
      chk_s("s3_sc0", got_sc[0], 8);
      chk_s("s3_sc1", got_sc[1], 8);
    end
    chk("s3_max", 64'(max), 64'({48'd11, 12'd2056}));

    // Backpressure: 20 results into a 16-entry FIFO, then a double rise
    threshold = '0;
    sif.out_ready = 1'b0;
    clr_got();
    for (int e = 0; e <= 22; e++) begin
      if (e % 5 == 0) begin
        for (int c = 0; c < C; c++) set_ch(c, IW'(100 + 4 * (e / 5) + c), 2048 + 2 * e + c);
        vld = '1;
      end else if (e == 22) begin
        set_ch(0, 48'd999, 2100);
        vld = vbit(0);
      end else begin
        vld = '0;
      end
      cyc();
      if (e == 21) chk("s4_dropped_pre", 64'(dropped), 64'd0);
      if (e == 22) chk("s4_dropped", 64'(dropped), 64'd1);
    end
    vld = '0;
    head = sif.out_id;
    chk("s4_valid", 64'(sif.out_valid), 64'd1);
    chk("s4_head_r0", 64'(head >= 100 && head < 104), 64'd1);
    repeat (3) cyc();
    chk("s4_hold_id", 64'(sif.out_id), 64'(head));
    sif.out_ready = 1'b1;
    repeat (30) cyc();
    chk("s4_count", 64'(got_id.size()), 64'd20);
    for (int i = 0; i <= 20; i++) begin
      cnt = 0;
      foreach (got_id[j]) if (got_id[j] == ((i == 20) ? IW'(999) : IW'(100 + i))) cnt++;
      chk("s4_once", 64'(cnt), (i == 20) ? 64'd0 : 64'd1);
    end

    // clear_max alone, then clear_max together with a grant
    clear_max = 1'b1; cyc(); clear_max = 1'b0;
    chk("s5_clr_max", 64'(max), 64'd0);
    chk("s5_clr_vld", 64'(vld_max), 64'd0);
    set_ch(0, 48'd40, 2088); vld = vbit(0); cyc(); vld = '0;
    repeat (3) cyc();
    chk("s5_prior", 64'(max), 64'({48'd40, 12'd2088}));
    set_ch(1, 48'd5, 2046); vld = vbit(1); cyc();
    clear_max = 1'b1; vld = '0; cyc(); clear_max = 1'b0;
    chk("s5_max", 64'(max), 64'({48'd5, 12'd2046}));
    chk("s5_vld_max", 64'(vld_max), 64'd1);

    // Reset mid-burst with entries queued and a valid held through it
    sif.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) set_ch(c, IW'(200 + c), 2060);
    vld = vbit(0) | vbit(1) | vbit(2);
    cyc(); vld = '0;
    repeat (5) cyc();
    chk("s6_queued", 64'(sif.out_valid), 64'd1);
    set_ch(3, 48'd300, 2070); vld = vbit(3); cyc();
    rst = 1'b0; cyc();
    chk("s6_valid", 64'(sif.out_valid), 64'd0);
    chk("s6_id", 64'(sif.out_id), 64'd0);
    chk_s("s6_score", sif.out_score, 0);
    chk("s6_max", 64'(max), 64'd0);
    chk("s6_vld_max", 64'(vld_max), 64'd0);
    chk("s6_dropped", 64'(dropped), 64'd0);
    rst = 1'b1;
    clr_got();
    sif.out_ready = 1'b1;
    repeat (12) cyc();
    vld = '0;
    cyc();
    chk("s6_count", 64'(got_id.size()), 64'd1);
    if (got_id.size() == 1) begin
      chk("s6_id_after", 64'(got_id[0]), 64'd300);
      chk_s("s6_sc_after", got_sc[0], 22);
    end

    // Randomized phase: sparse pulses, random backpressure and threshold
    thr = int'($urandom_range(400)) - 200;
    threshold = SW'(thr);
    clear_max = 1'b1; cyc(); clear_max = 1'b0;
    best = -1; nid = 0; prev_hold = 1'b0;
    for (int c = 0; c < C; c++) cool[c] = 0;
    for (int t = 0; t < 700; t++) begin
      if (prev_hold) begin
        chk("rnd_hold_id", 64'(sif.out_id), 64'(prev_id));
        chk_s("rnd_hold_sc", sif.out_score, int'(prev_sc));
      end
      sif.out_ready = (t >= 640) || ($urandom_range(7) != 0);
      if (sif.out_valid && sif.out_ready) begin
        fidx = -1;
        foreach (exp_q[i]) if (fidx < 0 && exp_q[i].id === sif.out_id) fidx = i;
        chk("rnd_known", 64'(fidx >= 0), 64'd1);
        if (fidx >= 0) begin
          chk_s("rnd_score", sif.out_score, exp_q[fidx].unb);
          exp_q.delete(fidx);
        end
      end
      prev_hold = sif.out_valid && !sif.out_ready;
      prev_id   = sif.out_id;
      prev_sc   = sif.out_score;
      for (int c = 0; c < C; c++) begin
        if (vld[C-1-c]) begin
          vld[C-1-c] = 1'b0;
          cool[c] = 10;
        end else if (cool[c] > 0) begin
          cool[c]--;
        end else if (t < 640 && $urandom_range(3) == 0) begin
          nid_v = {16'($urandom), 32'(5000 + nid)};
          nid++;
          bval = ZERO + int'($urandom_range(600)) - 300;
          set_ch(c, nid_v, bval);
          vld[C-1-c] = 1'b1;
          r.id = nid_v; r.biased = bval; r.unb = bval - ZERO;
          all_q.push_back(r);
          if (r.unb >= thr) exp_q.push_back(r);
          if (bval > best) best = bval;
        end
      end
      @(posedge clk);
      #1;
    end
    chk("rnd_left", 64'(exp_q.size()), 64'd0);
    chk("rnd_max_sc", 64'(max[SW-1:0]), 64'(best));
    found = 1'b0;
    foreach (all_q[i]) if (all_q[i].biased == best && all_q[i].id == max[IW+SW-1:SW]) found = 1'b1;
    chk("rnd_max_id", 64'(found), 64'd1);
    chk("rnd_vld_max", 64'(vld_max), 64'd1);
    chk("rnd_dropped", 64'(dropped), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
